apb_master: RTL and testbench

//  APB initiator (requester side) for the peripheral bus. Converts a simple valid/ready

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_addr_dec.sv | 21 ++
 rtl/apb_master.sv | 160 ++++++++++++++++
 tb/tb_apb_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states and default bus widths,
// used by the master and by peripheral slaves such as fifo_Periph.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_addr_dec.sv
// Slave-select decoder: 3-bit select field of the request address to
// slave index, one-hot select vector and a mapped/unmapped flag.
module apb_addr_dec #(
  parameter int NUM_SLV = 4
) (
  input  logic [2:0]         sel_field,
  output logic [2:0]         idx,
  output logic [NUM_SLV-1:0] sel,
  output logic               hit
);

  always_comb begin
    idx = sel_field;
    hit = ({1'b0, sel_field} < 4'(NUM_SLV));
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_field == 3'(i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into SETUP/ACCESS phases,
// waits on the selected PREADY with a timeout and returns data/error.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [2:0]          idx_q, idx_d;
  logic [NUM_SLV-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [2:0]          dec_idx;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_hit;
  logic [DATA_W-1:0]   prdata_sel;
  logic                pready_sel;

  apb_addr_dec #(.NUM_SLV(NUM_SLV)) u_dec (
    .sel_field (req_addr[SEL_LSB +: 3]),
    .idx       (dec_idx),
    .sel       (dec_sel),
    .hit       (dec_hit)
  );

  // Only the addressed slave's ready and data are ever looked at.
  always_comb begin
    prdata_sel = '0;
    pready_sel = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 3'(i)) begin
        prdata_sel = PRDATA[i*DATA_W +: DATA_W];
        pready_sel = PREADY[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    idx_d        = idx_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d = dec_idx;
          sel_d = dec_sel;
          if (dec_hit) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            write_d = req_write;
            cnt_d   = '0;
            state_d = SETUP;
          end else begin
            state_d = ERR;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_sel) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          rdata_d      = write_q ? '0 : prdata_sel;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = '0;
          end
        end
      end
      ERR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        rdata_d      = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign PSEL       = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
  assign PENABLE    = (state_q == ACCESS);
  assign PADDR      = addr_q;
  assign PWDATA     = wdata_q;
  assign PWRITE     = write_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: FIFO peripheral on slave 0, never-ready slave 1,
// always-ready constant slaves 2/3; responses checked against a scoreboard.
module tb_apb_master;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic         req_valid, req_write, req_ready;
  logic [31:0]  req_addr, req_wdata;
  logic         resp_valid, resp_err;
  logic [31:0]  resp_rdata;
  logic [31:0]  PADDR, PWDATA;
  logic         PWRITE, PENABLE;
  logic [3:0]   PSEL, PREADY;
  logic [127:0] PRDATA;

  int n_cmp = 0;
  int n_err = 0;
  int n_resp = 0;
  int n_exp = 0;
  logic [32:0] exp_q[$];

  logic [31:0] s0_mem [0:15];
  int s0_wr = 0, s0_rd = 0, s0_wait_cfg = 0, s0_wait_cnt = 0;

  always #5 PCLK = ~PCLK;

  apb_master dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // slave models
  always_comb begin
    PREADY = 4'b1100;
    PREADY[0] = PSEL[0] && PENABLE && (s0_wait_cnt >= s0_wait_cfg);
    PRDATA = '0;
    PRDATA[31:0]   = (PADDR[11:0] == 12'h008) ? s0_mem[s0_rd[3:0]]
                                              : {31'b0, s0_wr == s0_rd};
    PRDATA[63:32]  = 32'hDEAD_BEEF;
    PRDATA[95:64]  = 32'h2222_0002;
    PRDATA[127:96] = 32'h3333_0003;
  end

  always @(posedge PCLK) begin
    if (PSEL[0] && PENABLE) begin
      if (PREADY[0]) begin
        s0_wait_cnt <= 0;
        if (PWRITE && PADDR[11:0] == 12'h004) begin
          s0_mem[s0_wr[3:0]] <= PWDATA;
          s0_wr <= s0_wr + 1;
        end else if (!PWRITE && PADDR[11:0] == 12'h008) begin
          s0_rd <= s0_rd + 1;
        end
      end else begin
        s0_wait_cnt <= s0_wait_cnt + 1;
      end
    end else begin
      s0_wait_cnt <= 0;
    end
  end

  // response monitor / scoreboard pop
  always @(negedge PCLK) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'h1, 64'h0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_err", 64'(resp_err), 64'(e[32]));
        chk("resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
      end
      n_resp++;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd, input bit push);
    bit rdy = 0;
    if (push) begin
      exp_q.push_back({e_err, e_rd});
      n_exp++;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (req_ready) begin
        rdy = 1;
        break;
      end
    end
    if (!rdy) chk("ready_wait_timeout", 64'h0, 64'h1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge PCLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    bit done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      #1;
      if (n_resp >= n_exp) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("resp_wait_timeout", 64'h0, 64'h1);
  endtask

  initial begin
    int acc;
    int en_cnt;
    bit seen;
    bit stray;
    PRESET = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_psel", 64'(PSEL), 64'h0);
    chk("rst_penable", 64'(PENABLE), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_paddr", 64'(PADDR), 64'h0);
    chk("rst_rdata", 64'(resp_rdata), 64'h0);
    PRESET = 1'b1;

    // status read of empty FIFO
    issue(1'b0, 32'h0, 32'h0, 1'b0, 32'h1, 1'b1);
    wait_resp();

    // write 0xAA with phase checks
    issue(1'b1, 32'h4, 32'hAA, 1'b0, 32'h0, 1'b1);
    @(negedge PCLK);
    chk("setup_psel", 64'(PSEL), 64'h1);
    chk("setup_penable", 64'(PENABLE), 64'h0);
    chk("setup_paddr", 64'(PADDR), 64'h4);
    chk("setup_pwdata", 64'(PWDATA), 64'hAA);
    chk("setup_pwrite", 64'(PWRITE), 64'h1);
    chk("setup_req_ready", 64'(req_ready), 64'h0);
    @(negedge PCLK);
    chk("access_psel", 64'(PSEL), 64'h1);
    chk("access_penable", 64'(PENABLE), 64'h1);
    @(negedge PCLK);
    chk("lat_resp_valid", 64'(resp_valid), 64'h1);
    chk("lat_req_ready", 64'(req_ready), 64'h1);
    chk("lat_psel_clear", 64'(PSEL), 64'h0);
    wait_resp();

    // write 0xBB with 3 wait states and a stray request mid-transfer
    s0_wait_cfg = 3;
    issue(1'b1, 32'h4, 32'hBB, 1'b0, 32'h0, 1'b1);
    acc = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (resp_valid) begin
        seen = 1;
        break;
      end
      if (PENABLE) begin
        acc++;
        chk("ws_paddr", 64'(PADDR), 64'h4);
        chk("ws_pwdata", 64'(PWDATA), 64'hBB);
        chk("ws_pwrite", 64'(PWRITE), 64'h1);
        if (acc == 2) begin
          chk("ws_req_ready", 64'(req_ready), 64'h0);
          req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000;
        end
        if (acc == 3) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("ws_resp_seen", 64'(seen), 64'h1);
    chk("ws_access_cycles", 64'(acc), 64'd4);
    wait_resp();
    stray = 0;
    repeat (5) begin
      @(negedge PCLK);
      if (PSEL != 4'b0) stray = 1;
    end
    chk("ws_stray_ignored", 64'(stray), 64'h0);
    s0_wait_cfg = 0;

    // FIFO contents
    issue(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    wait_resp();
    issue(1'b0, 32'h8, 32'h0, 1'b0, 32'hAA, 1'b1);
    wait_resp();
    issue(1'b0, 32'h8, 32'h0, 1'b0, 32'hBB, 1'b1);
    wait_resp();

    // slave 1 never ready: timeout
    issue(1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b1);
    en_cnt = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (resp_valid) begin
        seen = 1;
        break;
      end
      if (PENABLE && PSEL == 4'b0010) en_cnt++;
    end
    chk("to_resp_seen", 64'(seen), 64'h1);
    chk("to_penable_cycles", 64'(en_cnt), 64'd16);
    chk("to_psel_clear", 64'(PSEL), 64'h0);
    wait_resp();

    // unmapped slave index 5
    issue(1'b0, 32'h5000, 32'h0, 1'b1, 32'h0, 1'b1);
    @(negedge PCLK);
    chk("unm_psel_err", 64'(PSEL), 64'h0);
    chk("unm_resp_early", 64'(resp_valid), 64'h0);
    @(negedge PCLK);
    chk("unm_resp_valid", 64'(resp_valid), 64'h1);
    chk("unm_psel_resp", 64'(PSEL), 64'h0);
    wait_resp();

    // constant slaves, data hold, write clears rdata
    issue(1'b0, 32'h3000, 32'h0, 1'b0, 32'h3333_0003, 1'b1);
    wait_resp();
    repeat (3) @(negedge PCLK);
    chk("rdata_hold", 64'(resp_rdata), 64'h3333_0003);
    issue(1'b0, 32'h2000, 32'h0, 1'b0, 32'h2222_0002, 1'b1);
    wait_resp();
    issue(1'b1, 32'h3000, 32'h1234, 1'b0, 32'h0, 1'b1);
    wait_resp();

    // reset during ACCESS aborts without response
    issue(1'b0, 32'h1000, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("abort_in_access", 64'(PENABLE), 64'h1);
    PRESET = 1'b0;
    @(posedge PCLK);
    #1 PRESET = 1'b1;
    @(negedge PCLK);
    chk("abort_psel", 64'(PSEL), 64'h0);
    chk("abort_penable", 64'(PENABLE), 64'h0);
    chk("abort_req_ready", 64'(req_ready), 64'h1);
    stray = 0;
    repeat (25) begin
      if (resp_valid) stray = 1;
      @(negedge PCLK);
    end
    chk("abort_no_resp", 64'(stray), 64'h0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
